itch_result_arbiter: RTL and testbench

- Merges the six per-type decoder result pulses (add, cancel, delete, replace, exec, trade) into one ordered, back-pressured result stream for the downstream order-book stage.
- Each source has a one-entry holding slot. A round-robin arbiter moves at most one slot per cycle into an output FIFO.
- A source pulse that arrives while its slot is occupied is dropped and counted.

---
 rtl/itch_result_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_itch_result_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/itch_result_arbiter.sv
// itch_result_arbiter
// Merges the six per-type ITCH decoder result pulses into one ordered,
// back-pressured stream. Each source owns a one-entry holding slot; a
// round-robin arbiter moves at most one slot per cycle into the output FIFO.
// Pulses that find their slot still occupied are dropped and counted.

module itch_result_arbiter #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               src_valid,
    input  logic [383:0]             src_ref,
    input  logic [191:0]             src_qty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_type,
    output logic [63:0]              out_ref,
    output logic [31:0]              out_qty,
    output logic                     drop_flag,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clr_drop,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int NSRC  = 6;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int ENT_W = 3 + 64 + 32;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Index of the source 'off' positions after 'base', wrapping modulo 6.
    function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
    endfunction

    // Holding slots
    logic [NSRC-1:0]   slot_vld_r;
    logic [63:0]       slot_ref_r [NSRC];
    logic [31:0]       slot_qty_r [NSRC];

    // Arbiter
    logic [2:0]        rr_ptr_r;
    logic [2:0]        cand_s;
    logic              grant_vld_s;
    logic [2:0]        grant_idx_s;
    logic [NSRC-1:0]   grant_oh_s;
    logic [NSRC-1:0]   cap_s;
    logic [NSRC-1:0]   drop_s;
    logic [2:0]        drop_num_s;

    // FIFO
    logic [ENT_W-1:0]  mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     rd_ptr_next_s;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_next_s;
    logic              push_s;
    logic              pop_s;
    logic [ENT_W-1:0]  wdata_s;
    logic [ENT_W-1:0]  head_next_s;
    logic              out_valid_r;
    logic [ENT_W-1:0]  out_ent_r;

    // Drop accounting
    logic              drop_flag_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic              flag_next_s;
    logic [CNT_W-1:0]  cnt_base_s;
    logic [CNT_W:0]    cnt_sum_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Round-robin search: scan offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 3'd0;
        cand_s      = 3'd0;
        if (level_r != FULL_LVL) begin
            for (int k = NSRC - 1; k >= 0; k--) begin
                cand_s = rr_idx(rr_ptr_r, 3'(k));
                if (slot_vld_r[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_idx_s = 3'd0;
        end
    end

    // A slot accepts a pulse when empty or when it is being drained this cycle; otherwise the pulse drops.
    always_comb begin
        grant_oh_s = 6'b000000;
        drop_num_s = 3'd0;
        if (grant_vld_s) begin
            grant_oh_s = 6'b000001 << grant_idx_s;
        end else begin
            grant_oh_s = 6'b000000;
        end
        cap_s  = src_valid & (~slot_vld_r | grant_oh_s);
        drop_s = src_valid & ~cap_s;
        for (int i = 0; i < NSRC; i++) begin
            drop_num_s = drop_num_s + {2'b00, drop_s[i]};
        end
    end

    // Next drop flag/count: a clear zeroes the base, same-cycle drops are then added with saturation.
    always_comb begin
        cnt_base_s  = {CNT_W{1'b0}};
        flag_next_s = 1'b0;
        if (clr_drop) begin
            cnt_base_s  = {CNT_W{1'b0}};
            flag_next_s = |drop_s;
        end else begin
            cnt_base_s  = drop_cnt_r;
            flag_next_s = drop_flag_r | (|drop_s);
        end
        cnt_sum_s = {1'b0, cnt_base_s} + (CNT_W + 1)'(drop_num_s);
        if (cnt_sum_s[CNT_W]) begin
            cnt_next_s = {CNT_W{1'b1}};
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // FIFO control and next head entry (bypasses the write when it lands at the new head).
    always_comb begin
        push_s  = grant_vld_s;
        pop_s   = out_valid_r & out_ready;
        wdata_s = {grant_idx_s, slot_ref_r[grant_idx_s], slot_qty_r[grant_idx_s]};
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        level_next_s = level_r + LW'(push_s) - LW'(pop_s);
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = wdata_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Slot occupancy and contents: load on capture, empty on grant, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_r <= 6'b000000;
            for (int i = 0; i < NSRC; i++) begin
                slot_ref_r[i] <= 64'd0;
                slot_qty_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (cap_s[i]) begin
                    slot_vld_r[i] <= 1'b1;
                    slot_ref_r[i] <= src_ref[64*i +: 64];
                    slot_qty_r[i] <= src_qty[32*i +: 32];
                end else if (grant_oh_s[i]) begin
                    slot_vld_r[i] <= 1'b0;
                end else begin
                    slot_vld_r[i] <= slot_vld_r[i];
                end
            end
        end
    end

    // Round-robin pointer moves just past the granted source; unchanged without a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= 3'd0;
        end else if (grant_vld_s) begin
            rr_ptr_r <= rr_idx(grant_idx_s, 3'd1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // FIFO pointers, level and the registered head presented on out_*.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_valid_r <= 1'b0;
            out_ent_r   <= {ENT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != {LW{1'b0}});
            out_ent_r   <= head_next_s;
        end
    end

    // Sticky drop flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_flag_r <= 1'b0;
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            drop_flag_r <= flag_next_s;
            drop_cnt_r  <= cnt_next_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_type   = out_ent_r[ENT_W-1 -: 3];
    assign out_ref    = out_ent_r[95:32];
    assign out_qty    = out_ent_r[31:0];
    assign drop_flag  = drop_flag_r;
    assign drop_count = drop_cnt_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_itch_result_arbiter.sv
// Directed testbench for itch_result_arbiter (DEPTH=8, CNT_W=16).

module tb_itch_result_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   src_valid;
    logic [383:0] src_ref;
    logic [191:0] src_qty;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_type;
    logic [63:0]  out_ref;
    logic [31:0]  out_qty;
    logic         drop_flag;
    logic [15:0]  drop_count;
    logic         clr_drop;
    logic [3:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    itch_result_arbiter #(.DEPTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ref    (src_ref),
        .src_qty    (src_qty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_ref    (out_ref),
        .out_qty    (out_qty),
        .drop_flag  (drop_flag),
        .drop_count (drop_count),
        .clr_drop   (clr_drop),
        .fifo_level (fifo_level)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [63:0] r, input logic [31:0] q);
        src_ref[64*i +: 64] = r;
        src_qty[32*i +: 32] = q;
    endtask

    // Directed stimulus sequence.
    initial begin
        rst       = 1'b0;
        src_valid = 6'b000000;
        src_ref   = '0;
        src_qty   = '0;
        out_ready = 1'b0;
        clr_drop  = 1'b0;
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_level", {60'd0, fifo_level}, 64'd0);
        check("rst_type", {61'd0, out_type}, 64'd0);
        check("rst_ref", out_ref, 64'd0);
        check("rst_qty", {32'd0, out_qty}, 64'd0);
        check("rst_flag", {63'd0, drop_flag}, 64'd0);
        check("rst_count", {48'd0, drop_count}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // All six at once from pointer 0: order 0..5.
        for (int i = 0; i < 6; i++) set_src(i, 64'hA0 + 64'(i), 32'd10 + 32'(i));
        src_valid = 6'b111111;
        out_ready = 1'b1;
        tick();
        src_valid = 6'b000000;
        check("six_slot_only", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("six_valid", {63'd0, out_valid}, 64'd1);
            check("six_type", {61'd0, out_type}, 64'(k));
            check("six_ref", out_ref, 64'hA0 + 64'(k));
            check("six_qty", {32'd0, out_qty}, 64'd10 + 64'(k));
            check("six_level", {60'd0, fifo_level}, 64'd1);
        end
        tick();
        check("six_empty", {63'd0, out_valid}, 64'd0);
        check("six_drops", {48'd0, drop_count}, 64'd0);

        // Single add: ref 0x11, qty 100.
        set_src(0, 64'h11, 32'd100);
        src_valid = 6'b000001;
        tick();
        src_valid = 6'b000000;
        check("add_latency", {63'd0, out_valid}, 64'd0);
        tick();
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_type", {61'd0, out_type}, 64'd0);
        check("add_ref", out_ref, 64'h11);
        check("add_qty", {32'd0, out_qty}, 64'd100);
        check("add_level", {60'd0, fifo_level}, 64'd1);
        tick();
        check("add_popped", {63'd0, out_valid}, 64'd0);
        check("add_level0", {60'd0, fifo_level}, 64'd0);

        // One cancel moves the pointer to 2.
        set_src(1, 64'h55, 32'd5);
        src_valid = 6'b000010;
        tick();
        src_valid = 6'b000000;
        tick();
        tick();
        check("ptr2_level0", {60'd0, fifo_level}, 64'd0);

        // Six at once from pointer 2: order 2,3,4,5,0,1.
        for (int i = 0; i < 6; i++) set_src(i, 64'hB0 + 64'(i), 32'd20 + 32'(i));
        src_valid = 6'b111111;
        tick();
        src_valid = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr2_type", {61'd0, out_type}, 64'((k + 2) % 6));
            check("rr2_ref", out_ref, 64'hB0 + 64'((k + 2) % 6));
        end
        tick();
        check("rr2_empty", {63'd0, out_valid}, 64'd0);

        // Three back-to-back cancels with no downstream accept.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_src(1, 64'h100 + 64'(k), 32'(k));
            src_valid = 6'b000010;
            tick();
        end
        src_valid = 6'b000000;
        tick();
        check("can_level", {60'd0, fifo_level}, 64'd3);
        check("can_drops", {48'd0, drop_count}, 64'd0);
        check("can_flag", {63'd0, drop_flag}, 64'd0);
        check("can_type", {61'd0, out_type}, 64'd1);
        tick();
        check("can_stable_ref", out_ref, 64'h100);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("can_ref", out_ref, 64'h100 + 64'(k));
            tick();
        end
        check("can_empty", {63'd0, out_valid}, 64'd0);

        // Exec every cycle until full: 9th held in slot, 10th dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_src(4, 64'h200 + 64'(k), 32'(k));
            src_valid = 6'b010000;
            tick();
        end
        src_valid = 6'b000000;
        check("full_level", {60'd0, fifo_level}, 64'd8);
        check("full_flag", {63'd0, drop_flag}, 64'd1);
        check("full_count", {48'd0, drop_count}, 64'd1);
        check("full_type", {61'd0, out_type}, 64'd4);
        check("full_head", out_ref, 64'h200);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        check("clr_flag", {63'd0, drop_flag}, 64'd0);
        check("clr_count", {48'd0, drop_count}, 64'd0);
        check("clr_level", {60'd0, fifo_level}, 64'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("drain_valid", {63'd0, out_valid}, 64'd1);
            check("drain_ref", out_ref, 64'h200 + 64'(k));
            check("drain_qty", {32'd0, out_qty}, 64'(k));
            tick();
        end
        check("drain_empty", {63'd0, out_valid}, 64'd0);
        check("drain_level", {60'd0, fifo_level}, 64'd0);

        // Reset with level 5 and three slots occupied (pointer starts at 5).
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) set_src(i, 64'hC0 + 64'(i), 32'd30 + 32'(i));
        src_valid = 6'b111111;
        tick();
        src_valid = 6'b000000;
        for (int k = 0; k < 4; k++) tick();
        src_valid = 6'b000011;
        tick();
        src_valid = 6'b000000;
        check("pre_rst_level", {60'd0, fifo_level}, 64'd5);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_level", {60'd0, fifo_level}, 64'd0);
        tick();
        rst = 1'b1;
        set_src(5, 64'hD5, 32'd55);
        src_valid = 6'b100000;
        out_ready = 1'b1;
        tick();
        src_valid = 6'b000000;
        check("post_rst_idle", {63'd0, out_valid}, 64'd0);
        tick();
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_type", {61'd0, out_type}, 64'd5);
        check("post_rst_ref", out_ref, 64'hD5);
        tick();
        check("post_rst_empty", {63'd0, out_valid}, 64'd0);
        check("post_rst_level", {60'd0, fifo_level}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
